ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the combinational instruction memory.
- Owns the fetch PC and drives the 11-bit word address into the memory. Captures the returned 32-bit word into a small prefetch FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Supports redirect from branch/jump resolution, which flushes all prefetched work.

Parameters:
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset.
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.
- AW, 11: instruction memory word-address width.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high reset.
- imem_a  out  AW: word address to instruction memory, equal to fetch_pc[AW+1:2].
- imem_rd  in  32: combinational read data for imem_a, valid in the same cycle.
- redirect_valid  in  1: load a new fetch PC and flush the queue.
- redirect_pc  in  32: redirect target; bits [1:0] are ignored (forced to 0).
- instr_valid  out  1: the queue head is valid.
- instr  out  32: instruction word at the queue head.
- instr_pc  out  32: byte PC of the queue head.
- instr_ready  in  1: decode accepts the head this cycle.
- fetch_pc  out  32: current fetch PC register (debug/trace).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - fetch_pc = RESET_PC, FIFO empty, pointers and count = 0.
  - instr_valid = 0; instr = 0 and instr_pc = 0.
- When instr_valid = 0, instr and instr_pc are driven to 0.
- pop = instr_valid & instr_ready.
- push = !redirect_valid & (count < DEPTH | pop).
  - A full queue accepts a push in the same cycle as a pop.
- On push:
  - Write entry {fetch_pc, imem_rd}.
  - fetch_pc <= fetch_pc + 4, with 32-bit modulo wrap (0xFFFF_FFFC -> 0x0000_0000).
- When no push occurs, fetch_pc holds, and imem_a therefore holds.
- Latency: a word pushed in cycle N is at the head in cycle N+1 when the queue was empty. The first instruction after reset release is therefore valid on the second edge.
- Redirect (highest priority):
  - A pop in the same cycle is honoured: that instruction counts as consumed.
  - Then all entries are flushed: count <= 0, rd_ptr = wr_ptr.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}. No push that cycle.
  - The next cycle has instr_valid = 0. The target instruction is valid one cycle later.
- Back-to-back redirects: each takes effect and the last one wins. The queue stays empty while redirect_valid is held.
- FIFO implementation:
  - rd_ptr and wr_ptr are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
  - Full: count == DEPTH. Empty: count == 0.
  - count' = count + push - pop, except after a flush.
- Ordering: instructions are delivered strictly in push order, with no duplication or loss without a redirect.
- Throughput: sustained 1 instruction/cycle when instr_ready stays high.
- Addresses beyond the memory alias: imem_a takes only bits [AW+1:2].

Decomposition:
- Shared package holds:
  - the RESET_PC default;
  - AW;
  - the instruction width (32);
  - the FIFO entry layout {pc[31:0], instr[31:0]}.
- Natural sub-module: ifq_fifo, a synchronous DEPTH-entry FIFO with push/pop/flush, full/empty/count, and async reset.
- The top level keeps the PC register, push/pop/redirect control, and output zeroing.

Test Plan:
1. Reset release with RESET_PC = 0 and instr_ready = 1:
   - imem_a steps 0, 1, 2, …
   - instr_valid rises on the second edge.
   - instr_pc runs 0x0, 0x4, 0x8, each matching the memory word.
2. instr_ready = 0 from reset:
   - Queue fills at 4 entries; fetch_pc stalls at 0x10 and imem_a at 4.
   - Head holds instr_pc = 0x0.
   - Releasing ready yields 0x0, 0x4, 0x8, 0xC, 0x10 … with no gap or duplicate.
3. Full queue with ready = 1: push and pop every cycle, count stays at 4, one instruction per cycle.
4. Redirect to 0x0000_0103 with 3 entries queued:
   - Next cycle: instr_valid = 0 and imem_a = 0x040.
   - Following cycle: instr_pc = 0x100 with the word at index 0x40.
5. Redirect and pop in the same cycle:
   - The popped PC appears exactly once.
   - No stale entry follows; the target arrives two cycles later.
6. Asynchronous reset mid-stream between edges:
   - instr_valid, instr and instr_pc go to 0 immediately.
   - fetch_pc = RESET_PC.
   - Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_queue_pkg
//   Shared definitions for the instruction-fetch queue:
//     - default reset PC, memory word-address width, FIFO depth
//     - instruction width
//     - prefetch FIFO entry layout {pc[31:0], instr[31:0]}
//     - PC alignment helper (clears the byte-offset bits)
// ---------------------------------------------------------------------------
package ifetch_queue_pkg;

    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
    localparam int          IFQ_AW       = 11;
    localparam int          IFQ_DEPTH    = 4;
    localparam int          ILEN         = 32;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } ifq_entry_t;

    // Instruction fetch is word granular; the low two bits are never used.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo
//   Synchronous DEPTH-entry FIFO of fetch entries with flush.
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     push, wr_data     write an entry (ignored when full without a pop,
//                       or when flush is asserted)
//     pop               remove the head entry (ignored when empty)
//     flush             discard all entries; takes priority over push/pop
//     rd_data           head entry (undefined content when empty)
//     full, empty       occupancy flags
//     count             number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  ifq_entry_t               wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output ifq_entry_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    ifq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & ~flush & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Dropping everything: the read side simply catches up to the write side.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Instruction-fetch front end in front of a combinational instruction
//   memory. Owns the fetch PC, prefetches words into a small FIFO and hands
//   them to decode. A redirect reloads the PC and flushes all prefetched work.
//   Ports:
//     clk, reset       clock, asynchronous active-high reset
//     imem_a           word address to instruction memory (fetch_pc[AW+1:2])
//     imem_rd          combinational read data for imem_a
//     redirect_valid   load redirect_pc (byte offset ignored) and flush
//     redirect_pc      redirect target
//     instr_valid      queue head is valid
//     instr, instr_pc  head instruction word and its byte PC (0 when invalid)
//     instr_ready      decode accepts the head this cycle
//     fetch_pc         current fetch PC register (trace)
//
//   Handshake: the head transfers on a rising edge where instr_valid and
//   instr_ready are both high. instr_valid depends only on queue state, never
//   combinationally on instr_ready; once raised, instr/instr_pc hold until the
//   transfer happens or a redirect/reset discards the entry.
// ---------------------------------------------------------------------------
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC,
    parameter int          DEPTH    = IFQ_DEPTH,
    parameter int          AW       = IFQ_AW
) (
    input  logic            clk,
    input  logic            reset,
    output logic [AW-1:0]   imem_a,
    input  logic [ILEN-1:0] imem_rd,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [31:0]     instr_pc,
    input  logic            instr_ready,
    output logic [31:0]     fetch_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ifq_entry_t       wr_entry;
    ifq_entry_t       head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;

    // Addresses beyond the memory alias onto it.
    assign imem_a = fetch_pc[AW+1:2];

    assign instr_valid = ~empty;
    assign pop         = instr_valid & instr_ready;
    // Redirect suppresses the fetch: the word at the old PC is stale.
    assign push        = ~redirect_valid & (~full | pop);

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = imem_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .flush   (redirect_valid),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Head storage is not reset, so mask it whenever nothing is valid.
    assign instr    = instr_valid ? head.instr : '0;
    assign instr_pc = instr_valid ? head.pc    : '0;

    count_in_range: assert property (@(posedge clk) disable iff (reset)
        count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    logic        clk;
    logic        reset;
    logic [10:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] fetch_pc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_fetch;
    } vec_t;

    vec_t vq[$];

    ifetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fetch_pc       (fetch_pc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: each word encodes its own address.
    function automatic logic [31:0] mem_word(input logic [10:0] a);
        return {16'hBEEF, 5'h00, a};
    endfunction

    assign imem_rd = mem_word(imem_a);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic v, input logic [31:0] pc, input logic [31:0] f);
        vec_t t;
        t.ready = r; t.redir = rd; t.rpc = rpc;
        t.exp_valid = v; t.exp_pc = pc; t.exp_fetch = f;
        return t;
    endfunction

    // Compare all observable outputs against an expected head/valid/fetch_pc.
    task automatic check_state(input string tag, input logic v, input logic [31:0] pc,
                               input logic [31:0] f);
        logic [31:0] exp_instr;
        logic [10:0] exp_a;
        exp_a     = f[12:2];
        exp_instr = v ? mem_word(pc[12:2]) : 32'h0;
        check({tag, " instr_valid"}, {31'h0, instr_valid}, {31'h0, v});
        check({tag, " instr_pc"}, instr_pc, v ? pc : 32'h0);
        check({tag, " instr"}, instr, exp_instr);
        check({tag, " fetch_pc"}, fetch_pc, f);
        check({tag, " imem_a"}, {21'h0, imem_a}, {21'h0, exp_a});
    endtask

    initial begin
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        //          ready redir rpc           valid pc            fetch
        // streaming from reset
        vq.push_back(mk(1, 0, 32'h0,          0, 32'h0,         32'h0));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'h0,         32'h4));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'h4,         32'h8));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'h8,         32'hC));
        // stall decode: queue fills, fetch stalls when full
        vq.push_back(mk(0, 0, 32'h0,          1, 32'hC,         32'h10));
        vq.push_back(mk(0, 0, 32'h0,          1, 32'hC,         32'h14));
        vq.push_back(mk(0, 0, 32'h0,          1, 32'hC,         32'h18));
        vq.push_back(mk(0, 0, 32'h0,          1, 32'hC,         32'h1C));
        vq.push_back(mk(0, 0, 32'h0,          1, 32'hC,         32'h1C));
        // full queue, ready: push and pop every cycle
        vq.push_back(mk(1, 0, 32'h0,          1, 32'hC,         32'h1C));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'h10,        32'h20));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'h14,        32'h24));
        // redirect with a full queue, byte offset ignored
        vq.push_back(mk(0, 1, 32'h0000_0103,  1, 32'h18,        32'h28));
        vq.push_back(mk(0, 0, 32'h0,          0, 32'h0,         32'h100));
        vq.push_back(mk(0, 0, 32'h0,          1, 32'h100,       32'h104));
        vq.push_back(mk(0, 0, 32'h0,          1, 32'h100,       32'h108));
        // redirect with three entries queued
        vq.push_back(mk(0, 1, 32'h2000_0040,  1, 32'h100,       32'h10C));
        vq.push_back(mk(1, 0, 32'h0,          0, 32'h0,         32'h2000_0040));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'h2000_0040, 32'h2000_0044));
        // redirect together with a pop, then back-to-back redirects
        vq.push_back(mk(1, 1, 32'h0000_0050,  1, 32'h2000_0044, 32'h2000_0048));
        vq.push_back(mk(1, 1, 32'h0000_0060,  0, 32'h0,         32'h50));
        vq.push_back(mk(1, 0, 32'h0,          0, 32'h0,         32'h60));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'h60,        32'h64));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'h64,        32'h68));
        // PC wrap at the top of the address space
        vq.push_back(mk(1, 1, 32'hFFFF_FFF9,  1, 32'h68,        32'h6C));
        vq.push_back(mk(1, 0, 32'h0,          0, 32'h0,         32'hFFFF_FFF8));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'hFFFF_FFF8, 32'hFFFF_FFFC));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'hFFFF_FFFC, 32'h0));
        vq.push_back(mk(1, 0, 32'h0,          1, 32'h0,         32'h4));

        // reset state while reset is held
        repeat (2) @(negedge clk);
        #1;
        check_state("reset", 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            instr_ready    = vq[i].ready;
            redirect_valid = vq[i].redir;
            redirect_pc    = vq[i].rpc;
            #1;
            check_state($sformatf("vec%0d", i), vq[i].exp_valid, vq[i].exp_pc, vq[i].exp_fetch);
            @(negedge clk);
        end

        // Asynchronous reset between edges while streaming.
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clk);
        #1;
        check("pre_reset instr_valid", {31'h0, instr_valid}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check_state("async_reset", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_state("restart0", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        check_state("restart1", 1'b1, 32'h0, 32'h4);
        @(negedge clk);
        #1;
        check_state("restart2", 1'b1, 32'h4, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
